// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB state encoding and default bus widths
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 8;
    localparam int unsigned APB_DATA_W = 32;

    // 2'b11 is unused; the master treats it as a fault and returns to IDLE
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_t;

endpackage

// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - APB bus signal bundle with master and slave views
interface apb_master_if #(
    parameter int unsigned ADDR_W = apb_pkg::APB_ADDR_W,
    parameter int unsigned DATA_W = apb_pkg::APB_DATA_W
);

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - ACCESS wait-state counter that flags a stalled slave
module apb_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic pclk,
    input  logic preset,
    input  logic clear,
    input  logic tick,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;

    // count ACCESS cycles in which the slave held pready low
    always_ff @(posedge pclk) begin
        if (preset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (tick && (count_q != CNT_MAX)) begin
            count_q <= count_q + 1'b1;
        end
    end

    // the wait cycle that brings the count to TIMEOUT_CYCLES ends the transfer
    assign expire = tick && (count_q == CNT_LAST);

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding APB requester (optional timeout: APB_MASTER_TIMEOUT_EN)
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W         = APB_ADDR_W,
    parameter int unsigned DATA_W         = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    apb_master_if.master      apb
);

    apb_state_t        state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .pclk  (pclk),
        .preset(preset),
        .clear (state_q == SETUP),
        .tick  ((state_q == ACCESS) && !apb.pready),
        .expire(timeout_hit)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout_hit    = 1'b0;
`endif

    // next state and next registered outputs; everything holds unless changed
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_write ? cmd_wdata : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (apb.pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = apb.pslverr;
                    rsp_rdata_d = pwrite_q ? '0 : apb.prdata;
                    state_d     = IDLE;
                end else if (timeout_hit) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // state and output registers; reset aborts any transfer in flight
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - scenario bench for apb_master with a transfer-level reference model
module tb_apb_master;

    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rsp_count = 0;

    logic [31:0] last_rdata;
    logic        last_err;

    apb_master_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    apb_master #(
        .ADDR_W(8),
        .DATA_W(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .pclk     (pclk),
        .preset   (preset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .apb      (bus)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;
    always @(negedge pclk) if (rsp_valid === 1'b1) rsp_count++;

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // One complete transfer starting in an IDLE cycle. Expected bus and
    // response values follow from the command and the slave's reply alone.
    task automatic run_transfer(input bit wr, input logic [7:0] addr,
                                input logic [31:0] wdata, input int waits,
                                input logic [31:0] rdata, input bit err,
                                input bit hold_valid);
        logic [31:0] exp_pwdata;
        logic [31:0] exp_rdata;
        exp_pwdata = wr ? wdata : 32'h0;
        exp_rdata  = wr ? 32'h0 : rdata;

        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_cmd_ready: got %b expected 1", cmd_ready);
        end
        step();

        if (hold_valid) begin
            cmd_write = ~wr;
            cmd_addr  = 8'($urandom);
            cmd_wdata = $urandom;
        end else begin
            cmd_valid = 1'b0;
        end
        checks++;
        if ({bus.psel, bus.penable, cmd_ready, rsp_valid} !== 4'b1000 ||
            bus.paddr !== addr || bus.pwrite !== wr || bus.pwdata !== exp_pwdata) begin
            errors++;
            $display("FAIL setup_phase: got sel/en/rdy/rv=%b addr=%h wr=%b wdata=%h expected 1000 addr=%h wr=%b wdata=%h",
                     {bus.psel, bus.penable, cmd_ready, rsp_valid}, bus.paddr, bus.pwrite,
                     bus.pwdata, addr, wr, exp_pwdata);
        end
        checks++;
        if (rsp_rdata !== last_rdata || rsp_err !== last_err) begin
            errors++;
            $display("FAIL rsp_hold: got rdata=%h err=%b expected rdata=%h err=%b",
                     rsp_rdata, rsp_err, last_rdata, last_err);
        end
        step();

        for (int i = 0; i <= waits; i++) begin
            bus.pready  = (i == waits);
            bus.prdata  = (i == waits) ? rdata : $urandom;
            bus.pslverr = (i == waits) ? err : 1'b1;
            checks++;
            if ({bus.psel, bus.penable, cmd_ready, rsp_valid} !== 4'b1100 ||
                bus.paddr !== addr || bus.pwrite !== wr || bus.pwdata !== exp_pwdata) begin
                errors++;
                $display("FAIL access_phase[%0d]: got sel/en/rdy/rv=%b addr=%h wr=%b wdata=%h expected 1100 addr=%h wr=%b wdata=%h",
                         i, {bus.psel, bus.penable, cmd_ready, rsp_valid}, bus.paddr,
                         bus.pwrite, bus.pwdata, addr, wr, exp_pwdata);
            end
            step();
        end

        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        cmd_valid   = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== err || rsp_rdata !== exp_rdata ||
            bus.psel !== 1'b0 || bus.penable !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL response: got rv=%b err=%b rdata=%h sel=%b en=%b rdy=%b expected rv=1 err=%b rdata=%h sel=0 en=0 rdy=1",
                     rsp_valid, rsp_err, rsp_rdata, bus.psel, bus.penable, cmd_ready,
                     err, exp_rdata);
        end
        last_rdata = exp_rdata;
        last_err   = err;
    endtask

    task automatic test_reset();
        preset      = 1'b1;
        cmd_valid   = 1'b1;
        cmd_write   = 1'b1;
        cmd_addr    = 8'h55;
        cmd_wdata   = 32'hFFFF_FFFF;
        bus.pready  = 1'b0;
        bus.prdata  = 32'h0;
        bus.pslverr = 1'b0;
        step();
        step();
        checks++;
        if ({bus.psel, bus.penable, bus.pwrite, rsp_valid, rsp_err, cmd_ready} !== 6'b000001 ||
            bus.paddr !== 8'h0 || bus.pwdata !== 32'h0 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got sel/en/wr/rv/err/rdy=%b addr=%h wdata=%h rdata=%h expected 000001 0 0 0",
                     {bus.psel, bus.penable, bus.pwrite, rsp_valid, rsp_err, cmd_ready},
                     bus.paddr, bus.pwdata, rsp_rdata);
        end
        cmd_valid = 1'b0;
        preset    = 1'b0;
        step();
        last_rdata = 32'h0;
        last_err   = 1'b0;
    endtask

    task automatic test_write_zero_wait();
        run_transfer(1'b1, 8'h10, 32'hDEAD_BEEF, 0, 32'hA5A5_A5A5, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_read_wait();
        run_transfer(1'b0, 8'h3C, 32'hCAFE_F00D, 3, 32'h1234_5678, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_error();
        run_transfer(1'b1, 8'hFF, 32'h0BAD_0BAD, 2, 32'h0, 1'b1, 1'b0);
        step();
        run_transfer(1'b0, 8'h01, 32'h0, 1, 32'h0000_0042, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_back_to_back();
        int start_cyc;
        int start_rsp;
        start_rsp = rsp_count;
        start_cyc = cyc;
        for (int k = 0; k < 3; k++) begin
            run_transfer(k[0], 8'(8'h20 + k), $urandom, 0, $urandom, 1'b0, 1'b1);
        end
        checks++;
        if (cyc - start_cyc !== 9) begin
            errors++;
            $display("FAIL b2b_span: got %0d cycles expected 9", cyc - start_cyc);
        end
        step();
        checks++;
        if (rsp_count - start_rsp !== 3) begin
            errors++;
            $display("FAIL b2b_rsp_count: got %0d expected 3", rsp_count - start_rsp);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++) begin
            run_transfer(1'($urandom), 8'($urandom), $urandom, int'($urandom_range(3, 0)),
                         $urandom, 1'($urandom), 1'b0);
            if ($urandom_range(1, 0) == 1) step();
        end
        step();
    endtask

    task automatic test_reset_mid_access();
        int start_rsp;
        start_rsp   = rsp_count;
        cmd_valid   = 1'b1;
        cmd_write   = 1'b1;
        cmd_addr    = 8'h77;
        cmd_wdata   = 32'h1111_2222;
        step();
        cmd_valid   = 1'b0;
        step();
        bus.pready  = 1'b0;
        step();
        preset      = 1'b1;
        bus.pready  = 1'b1;
        bus.pslverr = 1'b1;
        step();
        checks++;
        if ({bus.psel, bus.penable, rsp_valid} !== 3'b000 || bus.paddr !== 8'h0) begin
            errors++;
            $display("FAIL reset_abort: got sel/en/rv=%b addr=%h expected 000 addr=00",
                     {bus.psel, bus.penable, rsp_valid}, bus.paddr);
        end
        preset      = 1'b0;
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        step();
        step();
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_count !== start_rsp) begin
            errors++;
            $display("FAIL reset_recover: got rdy=%b rv=%b pulses=%0d expected rdy=1 rv=0 pulses=%0d",
                     cmd_ready, rsp_valid, rsp_count, start_rsp);
        end
        last_rdata = 32'h0;
        last_err   = 1'b0;
    endtask

`ifdef APB_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h44;
        cmd_wdata = 32'h0;
        step();
        cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            bus.pready = 1'b0;
            bus.prdata = $urandom;
            checks++;
            if ({bus.psel, bus.penable, rsp_valid} !== 3'b110) begin
                errors++;
                $display("FAIL timeout_wait[%0d]: got sel/en/rv=%b expected 110", i,
                         {bus.psel, bus.penable, rsp_valid});
            end
            step();
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || bus.psel !== 1'b0) begin
            errors++;
            $display("FAIL timeout_rsp: got rv=%b err=%b rdata=%h sel=%b expected 1 1 0 0",
                     rsp_valid, rsp_err, rsp_rdata, bus.psel);
        end
        last_rdata = 32'h0;
        last_err   = 1'b1;
        step();
        run_transfer(1'b0, 8'h45, 32'h0, 3, 32'h7777_8888, 1'b0, 1'b0);
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_error();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
`ifdef APB_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
